// File: rtl/dram_arbiter.sv
// Two-port arbiter for one single-port DRAM. A request accepted in IDLE completes with an ACK 3 cycles later.
// Requesters hold CS until ACK, and one transaction runs per 4 cycles. Ties go to round-robin or to A when FIXED_PRIO=1.
module dram_arbiter #(
   parameter int FIXED_PRIO = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] A_ADDR,
   input  logic        A_CS,
   input  logic        A_WR,
   input  logic [3:0]  A_MASK,
   input  logic [31:0] A_DIN,
   output logic [31:0] A_DOUT,
   output logic        A_ACK,
   input  logic [31:0] B_ADDR,
   input  logic        B_CS,
   input  logic        B_WR,
   input  logic [3:0]  B_MASK,
   input  logic [31:0] B_DIN,
   output logic [31:0] B_DOUT,
   output logic        B_ACK,
   output logic [31:0] DRAM_ADDR,
   output logic        DRAM_CS,
   output logic        DRAM_WR,
   output logic [3:0]  DRAM_MASK,
   output logic [31:0] DRAM_DIN,
   input  logic [31:0] DRAM_DOUT
);

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  mask;
      logic [31:0] din;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state, state_nxt;
   req_t        req, req_a, req_b;
   logic        gnt_b, last_b, win_b, take;
   logic [31:0] rd_data;

   assign req_a = '{addr: A_ADDR, wr: A_WR, mask: A_MASK, din: A_DIN};
   assign req_b = '{addr: B_ADDR, wr: B_WR, mask: B_MASK, din: B_DIN};

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      DRAM_CS   = 1'b0;
      DRAM_WR   = 1'b0;
      A_ACK     = 1'b0;
      B_ACK     = 1'b0;
      // On a tie the port not granted last wins, unless A has fixed priority.
      if (A_CS && B_CS) win_b = (FIXED_PRIO != 0) ? 1'b0 : !last_b;
      else              win_b = B_CS;
      if (!RST) begin
         case (state)
            IDLE: begin
               if (A_CS || B_CS) begin
                  take      = 1'b1;
                  state_nxt = ISSUE;
               end
            end
            ISSUE: begin
               DRAM_CS   = 1'b1;
               DRAM_WR   = req.wr;
               state_nxt = WAIT;
            end
            WAIT: state_nxt = DONE;
            DONE: begin
               A_ACK     = !gnt_b;
               B_ACK     = gnt_b;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         req     <= '0;
         gnt_b   <= 1'b0;
         last_b  <= 1'b1;
         rd_data <= '0;
      end else begin
         if (take) begin
            req    <= win_b ? req_b : req_a;
            gnt_b  <= win_b;
            last_b <= win_b;
         end
         // DRAM read data is registered, so it is valid during WAIT.
         if (state == WAIT && !req.wr) rd_data <= DRAM_DOUT;
      end
   end

   assign DRAM_ADDR = RST ? '0 : req.addr;
   assign DRAM_MASK = RST ? '0 : req.mask;
   assign DRAM_DIN  = RST ? '0 : req.din;
   assign A_DOUT    = RST ? '0 : rd_data;
   assign B_DOUT    = RST ? '0 : rd_data;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: round-robin and fixed-priority instances, each with a behavioural DRAM.
module tb_dram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a_addr, a_din, b_addr, b_din;
   logic        a_cs, a_wr, b_cs, b_wr;
   logic [3:0]  a_mask, b_mask;

   logic [31:0] a_dout, b_dout, dram_addr, dram_din, dram_dout;
   logic        a_ack, b_ack, dram_cs, dram_wr;
   logic [3:0]  dram_mask;

   logic [31:0] p_a_dout, p_b_dout, p_dram_addr, p_dram_din, p_dram_dout;
   logic        p_a_ack, p_b_ack, p_dram_cs, p_dram_wr;
   logic [3:0]  p_dram_mask;

   logic [31:0] mem0 [0:7];
   logic [31:0] mem1 [0:7];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dram_arbiter #(.FIXED_PRIO(0)) dut0 (
      .CLK(clk), .RST(rst),
      .A_ADDR(a_addr), .A_CS(a_cs), .A_WR(a_wr), .A_MASK(a_mask), .A_DIN(a_din),
      .A_DOUT(a_dout), .A_ACK(a_ack),
      .B_ADDR(b_addr), .B_CS(b_cs), .B_WR(b_wr), .B_MASK(b_mask), .B_DIN(b_din),
      .B_DOUT(b_dout), .B_ACK(b_ack),
      .DRAM_ADDR(dram_addr), .DRAM_CS(dram_cs), .DRAM_WR(dram_wr),
      .DRAM_MASK(dram_mask), .DRAM_DIN(dram_din), .DRAM_DOUT(dram_dout)
   );

   dram_arbiter #(.FIXED_PRIO(1)) dut1 (
      .CLK(clk), .RST(rst),
      .A_ADDR(a_addr), .A_CS(a_cs), .A_WR(a_wr), .A_MASK(a_mask), .A_DIN(a_din),
      .A_DOUT(p_a_dout), .A_ACK(p_a_ack),
      .B_ADDR(b_addr), .B_CS(b_cs), .B_WR(b_wr), .B_MASK(b_mask), .B_DIN(b_din),
      .B_DOUT(p_b_dout), .B_ACK(p_b_ack),
      .DRAM_ADDR(p_dram_addr), .DRAM_CS(p_dram_cs), .DRAM_WR(p_dram_wr),
      .DRAM_MASK(p_dram_mask), .DRAM_DIN(p_dram_din), .DRAM_DOUT(p_dram_dout)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                         input logic [3:0] mask);
      logic [31:0] r;
      r = old;
      for (int n = 0; n < 4; n++) if (mask[n]) r[8*n +: 8] = din[8*n +: 8];
      return r;
   endfunction

   // Word-addressed DRAMs with registered read data.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) mem0[i] <= '0;
         dram_dout <= '0;
      end else if (dram_cs) begin
         if (dram_wr) mem0[dram_addr[4:2]] <= merge(mem0[dram_addr[4:2]], dram_din, dram_mask);
         else         dram_dout <= mem0[dram_addr[4:2]];
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) mem1[i] <= '0;
         p_dram_dout <= '0;
      end else if (p_dram_cs) begin
         if (p_dram_wr) mem1[p_dram_addr[4:2]] <= merge(mem1[p_dram_addr[4:2]], p_dram_din, p_dram_mask);
         else           p_dram_dout <= mem1[p_dram_addr[4:2]];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_cs = 0; a_wr = 0; a_addr = '0; a_mask = '0; a_din = '0;
      b_cs = 0; b_wr = 0; b_addr = '0; b_mask = '0; b_din = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Drive one request on a single port until its ACK, return read data and ACK latency.
   task automatic run_one(input bit pb, input bit wr, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] din,
                          output logic [31:0] dout, output int lat);
      lat  = -1;
      dout = 'x;
      if (pb) begin b_cs = 1; b_wr = wr; b_addr = addr; b_mask = mask; b_din = din; end
      else    begin a_cs = 1; a_wr = wr; a_addr = addr; a_mask = mask; a_din = din; end
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (pb ? b_ack : a_ack) begin
            lat  = c;
            dout = pb ? b_dout : a_dout;
            break;
         end
      end
      a_cs = 0;
      b_cs = 0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      a_cs = 1; b_cs = 1; a_addr = 32'hFFFF_FFFF; a_din = 32'h1234_5678; a_mask = 4'hF;
      tick();
      tick();
      n_tests++; if (dram_cs !== 1'b0) begin n_fail++; $display("FAIL rst_dram_cs got=%b exp=0", dram_cs); end
      n_tests++; if (dram_wr !== 1'b0) begin n_fail++; $display("FAIL rst_dram_wr got=%b exp=0", dram_wr); end
      n_tests++; if ({dram_addr, dram_mask, dram_din} !== 68'd0) begin n_fail++;
         $display("FAIL rst_dram_bus got=%h/%h/%h exp=0", dram_addr, dram_mask, dram_din); end
      n_tests++; if ({a_ack, b_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_acks got=%b exp=00", {a_ack, b_ack}); end
      n_tests++; if ({a_dout, b_dout} !== 64'd0) begin n_fail++; $display("FAIL rst_dout got=%h/%h exp=0", a_dout, b_dout); end
      rst = 1'b0;
      tick();
      tick();
      tick();
      n_tests++; if ({a_ack, b_ack} !== 2'b10) begin n_fail++;
         $display("FAIL rst_first_tie acks(a,b) got=%b exp=10", {a_ack, b_ack}); end
      a_cs = 0; b_cs = 0;
      tick();
   endtask

   task automatic test_write_read();
      logic [31:0] d;
      int lat;
      do_reset();
      a_cs = 1; a_wr = 1; a_addr = 32'h10; a_mask = 4'hF; a_din = 32'hDEAD_BEEF;
      tick();
      n_tests++; if ({dram_cs, dram_wr} !== 2'b11) begin n_fail++;
         $display("FAIL wr_issue cs,wr got=%b exp=11", {dram_cs, dram_wr}); end
      n_tests++; if (dram_addr !== 32'h10 || dram_din !== 32'hDEAD_BEEF || dram_mask !== 4'hF) begin n_fail++;
         $display("FAIL wr_issue_bus got=%h/%h/%h exp=10/deadbeef/f", dram_addr, dram_din, dram_mask); end
      tick();
      n_tests++; if ({a_ack, dram_cs, dram_wr} !== 3'b000) begin n_fail++;
         $display("FAIL wr_wait ack,cs,wr got=%b exp=000", {a_ack, dram_cs, dram_wr}); end
      n_tests++; if (dram_addr !== 32'h10 || dram_din !== 32'hDEAD_BEEF) begin n_fail++;
         $display("FAIL wr_wait_stable got=%h/%h exp=10/deadbeef", dram_addr, dram_din); end
      tick();
      n_tests++; if ({a_ack, b_ack} !== 2'b10) begin n_fail++; $display("FAIL wr_ack got=%b exp=10", {a_ack, b_ack}); end
      a_cs = 0;
      tick();
      run_one(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, d, lat);
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL rd_b_latency got=%0d exp=3", lat); end
      n_tests++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_b_data got=%h exp=deadbeef", d); end
   endtask

   task automatic test_partial_write();
      logic [31:0] d;
      int lat;
      do_reset();
      run_one(1'b0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, d, lat);
      run_one(1'b1, 1'b1, 32'h20, 4'h2, 32'h0000_AA00, d, lat);
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL pw_b_latency got=%0d exp=3", lat); end
      run_one(1'b0, 1'b0, 32'h20, 4'hF, 32'h0, d, lat);
      n_tests++; if (d !== 32'h1122_AA44) begin n_fail++; $display("FAIL pw_readback got=%h exp=1122aa44", d); end
   endtask

   task automatic test_round_robin();
      int  cyc[$];
      bit  who[$];
      int  both = 0;
      do_reset();
      a_cs = 1; b_cs = 1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (a_ack && b_ack) both++;
         if (a_ack || b_ack) begin cyc.push_back(c); who.push_back(b_ack); end
      end
      a_cs = 0; b_cs = 0;
      tick();
      n_tests++; if (both != 0) begin n_fail++; $display("FAIL rr_dual_ack got=%0d exp=0", both); end
      n_tests++; if (cyc.size() != 4) begin n_fail++; $display("FAIL rr_ack_count got=%0d exp=4", cyc.size()); end
      for (int k = 0; k < cyc.size() && k < 4; k++) begin
         n_tests++; if (who[k] !== k[0] || cyc[k] != 3 + 4 * k) begin n_fail++;
            $display("FAIL rr_ack%0d port_b,cycle got=%b,%0d exp=%b,%0d", k, who[k], cyc[k], k[0], 3 + 4 * k); end
      end
   endtask

   task automatic test_fixed_prio();
      int na = 0;
      int nb_early = 0;
      int b_cyc = -1;
      int last_a = -1;
      do_reset();
      a_cs = 1; b_cs = 1;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (p_b_ack) begin
            if (na < 4) nb_early++;
            b_cyc = c;
            break;
         end
         if (p_a_ack) begin
            na++;
            n_tests++; if (c != 4 * na - 1) begin n_fail++;
               $display("FAIL fp_a_ack%0d cycle got=%0d exp=%0d", na, c, 4 * na - 1); end
            last_a = c;
            if (na == 4) a_cs = 0;
         end
      end
      a_cs = 0; b_cs = 0;
      tick();
      n_tests++; if (na != 4 || nb_early != 0) begin n_fail++;
         $display("FAIL fp_a_only a_acks,early_b got=%0d,%0d exp=4,0", na, nb_early); end
      n_tests++; if (b_cyc != last_a + 4) begin n_fail++;
         $display("FAIL fp_b_after_drop cycle got=%0d exp=%0d", b_cyc, last_a + 4); end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      a_cs = 1; a_wr = 0; a_addr = 32'h10; a_mask = 4'hF;
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_tests++; if ({a_ack, b_ack, dram_cs} !== 3'b000) begin n_fail++;
         $display("FAIL rmid_in_reset ack_a,ack_b,cs got=%b exp=000", {a_ack, b_ack, dram_cs}); end
      b_cs = 1;
      rst = 1'b0;
      tick();
      n_tests++; if ({a_ack, dram_cs} !== 2'b01) begin n_fail++;
         $display("FAIL rmid_fresh_issue ack,cs got=%b exp=01", {a_ack, dram_cs}); end
      tick();
      tick();
      n_tests++; if ({a_ack, b_ack} !== 2'b10) begin n_fail++;
         $display("FAIL rmid_a_wins got=%b exp=10", {a_ack, b_ack}); end
      a_cs = 0; b_cs = 0;
      tick();
   endtask

   task automatic test_early_drop();
      int extra_ack = 0;
      int extra_cs = 0;
      do_reset();
      b_cs = 1; b_wr = 0; b_addr = 32'h10; b_mask = 4'hF;
      tick();
      n_tests++; if (dram_cs !== 1'b1) begin n_fail++; $display("FAIL ed_issue cs got=%b exp=1", dram_cs); end
      b_cs = 0;
      tick();
      tick();
      n_tests++; if ({a_ack, b_ack} !== 2'b01) begin n_fail++; $display("FAIL ed_b_ack got=%b exp=01", {a_ack, b_ack}); end
      for (int c = 0; c < 8; c++) begin
         tick();
         if (a_ack || b_ack) extra_ack++;
         if (dram_cs) extra_cs++;
      end
      n_tests++; if (extra_ack != 0 || extra_cs != 0) begin n_fail++;
         $display("FAIL ed_no_repeat acks,cs got=%0d,%0d exp=0,0", extra_ack, extra_cs); end
   endtask

   // Random traffic against a word-level memory model; ties resolved from the last grant.
   task automatic test_random();
      logic [31:0] ref_mem [0:7];
      bit          last_b_m;
      do_reset();
      for (int i = 0; i < 8; i++) ref_mem[i] = '0;
      last_b_m = 1'b1;
      for (int it = 0; it < 40; it++) begin
         logic [31:0] r_addr [2];
         logic [31:0] r_din  [2];
         logic [3:0]  r_mask [2];
         bit          r_wr   [2];
         bit          ord    [2];
         logic [31:0] exp_d  [2];
         logic [31:0] got_d  [2];
         int          got_c  [2];
         bit          got_b  [2];
         int          p, nexp, nack;
         bit          cur;
         p = int'($urandom_range(1, 3));
         for (int q = 0; q < 2; q++) begin
            r_addr[q] = $urandom;
            r_din[q]  = $urandom;
            r_mask[q] = 4'($urandom);
            r_wr[q]   = 1'($urandom);
            exp_d[q]  = '0;
            got_d[q]  = '0;
            got_c[q]  = -1;
            got_b[q]  = 1'b0;
         end
         if (p == 3) begin nexp = 2; ord[0] = !last_b_m; ord[1] = last_b_m; end
         else        begin nexp = 1; ord[0] = (p == 2);  ord[1] = 1'b0; end
         for (int k = 0; k < nexp; k++) begin
            if (r_wr[ord[k]]) ref_mem[r_addr[ord[k]][4:2]] = merge(ref_mem[r_addr[ord[k]][4:2]], r_din[ord[k]], r_mask[ord[k]]);
            else              exp_d[k] = ref_mem[r_addr[ord[k]][4:2]];
            last_b_m = ord[k];
         end
         a_addr = r_addr[0]; a_din = r_din[0]; a_mask = r_mask[0]; a_wr = r_wr[0]; a_cs = p[0];
         b_addr = r_addr[1]; b_din = r_din[1]; b_mask = r_mask[1]; b_wr = r_wr[1]; b_cs = p[1];
         nack = 0;
         for (int c = 1; c <= 12 && nack < nexp; c++) begin
            tick();
            if (dram_cs) begin
               cur = ord[nack];
               n_tests++; if (dram_addr !== r_addr[cur] || dram_wr !== r_wr[cur]) begin n_fail++;
                  $display("FAIL rnd%0d_issue addr,wr got=%h,%b exp=%h,%b", it, dram_addr, dram_wr, r_addr[cur], r_wr[cur]); end
            end
            if (a_ack && b_ack) begin
               n_tests++; n_fail++; $display("FAIL rnd%0d_dual_ack got=11 exp=one-hot", it);
            end
            if (a_ack || b_ack) begin
               if (nack < 2) begin
                  got_b[nack] = b_ack; got_c[nack] = c; got_d[nack] = b_ack ? b_dout : a_dout;
               end
               nack++;
               if (a_ack) a_cs = 0;
               if (b_ack) b_cs = 0;
            end
         end
         a_cs = 0; b_cs = 0;
         tick();
         n_tests++; if (nack != nexp) begin n_fail++; $display("FAIL rnd%0d_ack_count got=%0d exp=%0d", it, nack, nexp); end
         for (int k = 0; k < nexp && k < nack; k++) begin
            n_tests++; if (got_b[k] !== ord[k] || got_c[k] != 3 + 4 * k) begin n_fail++;
               $display("FAIL rnd%0d_ack%0d port_b,cycle got=%b,%0d exp=%b,%0d", it, k, got_b[k], got_c[k], ord[k], 3 + 4 * k); end
            if (!r_wr[ord[k]]) begin
               n_tests++; if (got_d[k] !== exp_d[k]) begin n_fail++;
                  $display("FAIL rnd%0d_rdata%0d got=%h exp=%h", it, k, got_d[k], exp_d[k]); end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_write_read();
      test_partial_write();
      test_round_robin();
      test_fixed_prio();
      test_reset_mid_op();
      test_early_drop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0; 0 selects round-robin and 1 makes port A always win ties.
REQ-002 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 A_ADDR  input  32  port A byte address.
REQ-005 A_CS  input  1  port A request; held high until A_ACK.
REQ-006 A_WR  input  1  port A write (1) or read (0).
REQ-007 A_MASK  input  4  port A byte enables; bit n covers DIN[8n+7:8n].
REQ-008 A_DIN  input  32  port A write data.
REQ-009 A_DOUT  output  32  port A read data, valid while A_ACK is high.
REQ-010 A_ACK  output  1  one-cycle port A completion pulse.
REQ-011 B_ADDR, B_CS, B_WR, B_MASK, B_DIN, B_DOUT, B_ACK SHALL be port B equivalents of REQ-004 to REQ-010, with identical widths and directions.
REQ-012 DRAM_ADDR  output  32  address to the shared single-port DRAM.
REQ-013 DRAM_CS  output  1  DRAM select.
REQ-014 DRAM_WR  output  1  DRAM write strobe.
REQ-015 DRAM_MASK  output  4  DRAM byte enables.
REQ-016 DRAM_DIN  output  32  DRAM write data.
REQ-017 DRAM_DOUT  input  32  DRAM read data, registered inside the DRAM and valid the cycle after DRAM_CS is sampled.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, with transitions IDLE->ISSUE when A_CS or B_CS is high, ISSUE->WAIT, WAIT->DONE and DONE->IDLE, all unconditional except IDLE.
REQ-019 In IDLE the arbiter SHALL select the winner and register its ADDR, WR, MASK and DIN plus a grant flag.
REQ-020 With a single requester, that requester SHALL win.
REQ-021 On a tie with FIXED_PRIO=0, the port not granted last SHALL win; on a tie with FIXED_PRIO=1, A SHALL win.
REQ-022 DRAM_CS SHALL be high only in ISSUE, and DRAM_WR SHALL equal the latched WR only in ISSUE; both SHALL be 0 in every other state.
REQ-023 DRAM_ADDR, DRAM_MASK and DRAM_DIN SHALL come from the latched request and remain stable from ISSUE through DONE.
REQ-024 In WAIT the arbiter SHALL capture DRAM_DOUT into a 32-bit read register on a read, and SHALL leave the register unchanged on a write.
REQ-025 In DONE only the granted port's ACK SHALL be high, and both A_DOUT and B_DOUT SHALL show the read register.
REQ-026 ACK SHALL occur exactly 3 cycles after the IDLE cycle in which the request was accepted, and the block SHALL service at most 1 transaction per 4 cycles.
REQ-027 Requests seen in ISSUE, WAIT and DONE SHALL be ignored, and arbitration SHALL happen only in IDLE, so a CS still high during DONE is never serviced twice.
REQ-028 A CS still high in the IDLE cycle after ACK SHALL be treated as a new back-to-back request.
REQ-029 A requester that drops CS after acceptance SHALL not abort the transaction, which SHALL complete and still pulse ACK.
REQ-030 The arbiter SHALL not alter address bits; DRAM word select is ADDR[31:2] and belongs to the DRAM.
REQ-031 A_ACK and B_ACK SHALL never be high in the same cycle.

Reset
REQ-032 While RST is high, the block SHALL force state IDLE, all DRAM_* outputs 0, A_ACK=B_ACK=0, the read register 0, and the last-grant flag to B, so A wins the first tie.
REQ-033 RST asserted mid-transaction SHALL abandon that transaction with no ACK, and after RST is released, pending requests SHALL be arbitrated fresh from IDLE.

Verification
REQ-034 Write A: A_CS=1, A_WR=1, A_ADDR=0x10, A_MASK=0xF, A_DIN=0xDEADBEEF -> DRAM_CS=DRAM_WR=1 one cycle later, A_ACK 3 cycles after acceptance; then a B read of 0x10 -> B_DOUT=0xDEADBEEF with B_ACK.
REQ-035 Partial write: 0x11223344 stored, then B writes MASK=0x2, DIN=0x0000AA00 -> a subsequent read returns 0x1122AA44.
REQ-036 Round-robin: A and B held high for 4 transactions with FIXED_PRIO=0 -> ACK order A,B,A,B, spaced 4 cycles apart.
REQ-037 Fixed priority: the same stimulus with FIXED_PRIO=1 -> all ACKs go to A while A_CS stays high, and B is served only after A drops.
REQ-038 Reset mid-op: RST pulsed during WAIT of an A read -> no A_ACK, DRAM_CS=0; after release with both requesting -> A wins.
REQ-039 Early drop: B_CS dropped in ISSUE -> B_ACK still pulses in DONE, and no second B transaction follows.
